// File: rtl/dll_pkg.sv
// Shared types for the FMDLL lock controller: FSM states, window classes and
// the count classifier used once per reference window.
package dll_pkg;

  localparam int unsigned DLL_CODE_W = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_SETTLE,
    S_LOCKED
  } dll_state_e;

  typedef enum logic [1:0] {
    C_MATCH,
    C_LEAD,
    C_LAG,
    C_INVALID
  } dll_class_e;

  // nq at or below N/2 means the line is far too fast: push the code up.
  function automatic dll_class_e dll_classify(input logic [3:0] nq,
                                              input logic [3:0] n);
    logic [3:0] half;
    half = n >> 1;
    if ((nq == 4'd0) || (nq > n)) return C_INVALID;
    if (nq == n)                  return C_MATCH;
    if (nq > half)                return C_LAG;
    return C_LEAD;
  endfunction

endpackage

// File: rtl/dll_cnt_sync.sv
// Brings the clk_out-domain N count into clk_ext: two-flop synchronizer per
// bit, then a filter that only accepts a value seen on two consecutive cycles.
module dll_cnt_sync #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  logic [W-1:0] r_prev;
  logic [W-1:0] r_q;

  // Bits may resolve on different cycles while the count moves; holding the
  // old value until two samples agree hides those mixed codes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
      r_prev <= r_sync;
      if (r_sync == r_prev) r_q <= r_sync;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/dll_lock_ctrl.sv
// FMDLL lock controller: classifies the synchronized N count once per reference
// window, steps a saturating delay-line code and tracks lock with hysteresis.
module dll_lock_ctrl
  import dll_pkg::*;
#(
  parameter int unsigned CODE_W     = DLL_CODE_W,
  parameter int unsigned CODE_RST   = 32,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 2,
  parameter int unsigned SETTLE     = 2
) (
  input  logic              clk_ext,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        M,
  input  logic [3:0]        N,
  input  logic [1:0]        M_counter,
  input  logic [3:0]        N_counter,
  output logic [CODE_W-1:0] ctrl_code,
  output logic              up,
  output logic              dn,
  output logic              locked,
  output logic              err
);

  localparam logic [CODE_W-1:0] CODE_INIT   = CODE_W'(CODE_RST);
  localparam logic [CODE_W-1:0] CODE_MAX    = '1;
  localparam logic [7:0]        LOCK_TH     = 8'(LOCK_CNT);
  localparam logic [7:0]        UNLOCK_TH   = 8'(UNLOCK_CNT);
  localparam logic [7:0]        SETTLE_TH   = 8'(SETTLE);
  localparam bit                SKIP_SETTLE = (SETTLE == 0);

  logic [3:0]        w_nq;
  logic              r_win;
  dll_class_e        w_cls;

  dll_state_e        r_state,      w_state;
  logic [CODE_W-1:0] r_code,       w_code;
  logic              r_up,         w_up;
  logic              r_dn,         w_dn;
  logic              r_err,        w_err;
  logic              r_locked,     w_locked;
  logic [7:0]        r_match_run,  w_match_run;
  logic [7:0]        r_miss_run,   w_miss_run;
  logic [7:0]        r_settle_cnt, w_settle_cnt;
  logic              r_ret_locked, w_ret_locked;

  logic [CODE_W-1:0] w_code_inc;
  logic [CODE_W-1:0] w_code_dec;

  dll_cnt_sync #(.W(4)) u_sync (
    .clk (clk_ext),
    .rst (rst),
    .d   (N_counter),
    .q   (w_nq)
  );

  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) r_win <= 1'b0;
    else     r_win <= (M_counter == M);
  end

  assign w_cls      = dll_classify(w_nq, N);
  assign w_code_inc = (r_code == CODE_MAX) ? r_code : r_code + 1'b1;
  assign w_code_dec = (r_code == '0)       ? r_code : r_code - 1'b1;

  always_comb begin
    w_state      = r_state;
    w_code       = r_code;
    w_up         = 1'b0;
    w_dn         = 1'b0;
    w_err        = 1'b0;
    w_locked     = r_locked;
    w_match_run  = r_match_run;
    w_miss_run   = r_miss_run;
    w_settle_cnt = r_settle_cnt;
    w_ret_locked = r_ret_locked;

    if (!en) begin
      w_state      = S_IDLE;
      w_code       = CODE_INIT;
      w_locked     = 1'b0;
      w_match_run  = '0;
      w_miss_run   = '0;
      w_settle_cnt = '0;
      w_ret_locked = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_code       = CODE_INIT;
          w_locked     = 1'b0;
          w_match_run  = '0;
          w_miss_run   = '0;
          w_settle_cnt = '0;
          w_ret_locked = 1'b0;
          w_state      = S_ACQ;
        end

        S_ACQ: begin
          if (r_win) begin
            case (w_cls)
              C_MATCH: begin
                if (r_match_run + 8'd1 >= LOCK_TH) begin
                  w_state     = S_LOCKED;
                  w_locked    = 1'b1;
                  w_match_run = '0;
                  w_miss_run  = '0;
                end else begin
                  w_match_run = r_match_run + 8'd1;
                end
              end
              C_LEAD, C_LAG: begin
                w_up         = (w_cls == C_LEAD);
                w_dn         = (w_cls == C_LAG);
                w_code       = (w_cls == C_LEAD) ? w_code_inc : w_code_dec;
                w_match_run  = '0;
                w_settle_cnt = '0;
                w_ret_locked = 1'b0;
                w_state      = SKIP_SETTLE ? S_ACQ : S_SETTLE;
              end
              default: begin
                w_err       = 1'b1;
                w_match_run = '0;
              end
            endcase
          end
        end

        S_SETTLE: begin
          if (r_win) begin
            if (r_settle_cnt + 8'd1 >= SETTLE_TH) begin
              w_settle_cnt = '0;
              w_state      = r_ret_locked ? S_LOCKED : S_ACQ;
            end else begin
              w_settle_cnt = r_settle_cnt + 8'd1;
            end
          end
        end

        S_LOCKED: begin
          if (r_win) begin
            if (w_cls == C_MATCH) begin
              w_miss_run = '0;
            end else begin
              w_up  = (w_cls == C_LEAD);
              w_dn  = (w_cls == C_LAG);
              w_err = (w_cls == C_INVALID);
              if (w_cls == C_LEAD) w_code = w_code_inc;
              if (w_cls == C_LAG)  w_code = w_code_dec;
              // Losing lock wins over settling: the loop restarts acquisition
              // straight away with the code already stepped.
              if (r_miss_run + 8'd1 >= UNLOCK_TH) begin
                w_locked    = 1'b0;
                w_state     = S_ACQ;
                w_miss_run  = '0;
                w_match_run = '0;
              end else begin
                w_miss_run = r_miss_run + 8'd1;
                if (w_cls != C_INVALID) begin
                  w_settle_cnt = '0;
                  w_ret_locked = 1'b1;
                  w_state      = SKIP_SETTLE ? S_LOCKED : S_SETTLE;
                end
              end
            end
          end
        end

        default: w_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_code       <= CODE_INIT;
      r_up         <= 1'b0;
      r_dn         <= 1'b0;
      r_err        <= 1'b0;
      r_locked     <= 1'b0;
      r_match_run  <= '0;
      r_miss_run   <= '0;
      r_settle_cnt <= '0;
      r_ret_locked <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_code       <= w_code;
      r_up         <= w_up;
      r_dn         <= w_dn;
      r_err        <= w_err;
      r_locked     <= w_locked;
      r_match_run  <= w_match_run;
      r_miss_run   <= w_miss_run;
      r_settle_cnt <= w_settle_cnt;
      r_ret_locked <= w_ret_locked;
    end
  end

  assign ctrl_code = r_code;
  assign up        = r_up;
  assign dn        = r_dn;
  assign err       = r_err;
  assign locked    = r_locked;

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Scoreboard bench for dll_lock_ctrl: stimulus queues expected output events,
// a monitor pops and compares whenever an output pulses or changes.
module tb_dll_lock_ctrl;

  logic       clk_ext   = 1'b0;
  logic       rst       = 1'b1;
  logic       en        = 1'b0;
  logic [1:0] M         = 2'd2;
  logic [3:0] N         = 4'd8;
  logic [1:0] M_counter = 2'd1;
  logic [3:0] N_counter = 4'd0;
  logic [5:0] ctrl_code;
  logic       up, dn, locked, err;

  typedef struct packed {
    logic       up;
    logic       dn;
    logic       err;
    logic       locked;
    logic [5:0] code;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        mon_cur;
  rec_t        mon_prev  = {1'b0, 1'b0, 1'b0, 1'b0, 6'd32};
  rec_t        mon_exp;
  rec_t        probe_exp = '0;
  int unsigned probe_seq  = 0;
  int unsigned probe_seen = 0;
  logic        fin_req    = 1'b0;
  int unsigned n_checks   = 0;
  int unsigned n_errors   = 0;

  dll_lock_ctrl #(
    .CODE_W    (6),
    .CODE_RST  (32),
    .LOCK_CNT  (4),
    .UNLOCK_CNT(2),
    .SETTLE    (2)
  ) dut (
    .clk_ext  (clk_ext),
    .rst      (rst),
    .en       (en),
    .M        (M),
    .N        (N),
    .M_counter(M_counter),
    .N_counter(N_counter),
    .ctrl_code(ctrl_code),
    .up       (up),
    .dn       (dn),
    .locked   (locked),
    .err      (err)
  );

  always #5 clk_ext = ~clk_ext;

  // Monitor: sole owner of the check/error counters and of the summary line.
  always @(posedge clk_ext) begin
    #1;
    mon_cur = {up, dn, err, locked, ctrl_code};
    if (up || dn || err || (locked !== mon_prev.locked) || (ctrl_code !== mon_prev.code)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_event got up=%b dn=%b err=%b locked=%b code=%0d (none queued)",
                 mon_cur.up, mon_cur.dn, mon_cur.err, mon_cur.locked, mon_cur.code);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_cur !== mon_exp) begin
          n_errors++;
          $display("FAIL event got up=%b dn=%b err=%b locked=%b code=%0d exp up=%b dn=%b err=%b locked=%b code=%0d",
                   mon_cur.up, mon_cur.dn, mon_cur.err, mon_cur.locked, mon_cur.code,
                   mon_exp.up, mon_exp.dn, mon_exp.err, mon_exp.locked, mon_exp.code);
        end
      end
    end
    mon_prev = mon_cur;

    if (probe_seq != probe_seen) begin
      probe_seen = probe_seq;
      n_checks++;
      if (mon_cur !== probe_exp) begin
        n_errors++;
        $display("FAIL probe%0d got up=%b dn=%b err=%b locked=%b code=%0d exp up=%b dn=%b err=%b locked=%b code=%0d",
                 probe_seq, mon_cur.up, mon_cur.dn, mon_cur.err, mon_cur.locked, mon_cur.code,
                 probe_exp.up, probe_exp.dn, probe_exp.err, probe_exp.locked, probe_exp.code);
      end
    end

    if (fin_req) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_errors++;
        $display("FAIL missing_events got %0d still queued exp 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_ext);
  endtask

  // One reference window: M_counter hits M for exactly one cycle.
  task automatic window(input int n);
    repeat (n) begin
      @(negedge clk_ext) M_counter = 2'd2;
      @(negedge clk_ext) M_counter = 2'd1;
    end
  endtask

  // Pause windows while the new count crosses the synchronizer and filter.
  task automatic set_n(input logic [3:0] v);
    @(negedge clk_ext);
    M_counter = 2'd1;
    N_counter = v;
    tick(6);
  endtask

  task automatic expect_ev(input logic u, input logic d, input logic e,
                           input logic l, input int c);
    rec_t r;
    r = {u, d, e, l, 6'(c)};
    exp_q.push_back(r);
  endtask

  task automatic probe(input logic l, input int c);
    tick(2);
    probe_exp = {1'b0, 1'b0, 1'b0, l, 6'(c)};
    probe_seq++;
    tick(2);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    probe(1'b0, 32);

    // Steady match: lock after four windows, code untouched.
    en = 1'b1;
    set_n(4'd8);
    expect_ev(0, 0, 0, 1, 32);
    window(4);
    probe(1'b1, 32);

    // Two LAG misses while locked (settle between them) drop lock.
    set_n(4'd5);
    expect_ev(0, 1, 0, 1, 31);
    expect_ev(0, 1, 0, 0, 30);
    window(4);
    probe(1'b0, 30);

    // LAG in acquisition: dn on every third window.
    set_n(4'd6);
    expect_ev(0, 1, 0, 0, 29);
    expect_ev(0, 1, 0, 0, 28);
    expect_ev(0, 1, 0, 0, 27);
    window(9);
    probe(1'b0, 27);

    // Out-of-range counts pulse err and restart the match run.
    set_n(4'd8);
    window(3);
    set_n(4'd12);
    expect_ev(0, 0, 1, 0, 27);
    window(1);
    set_n(4'd0);
    expect_ev(0, 0, 1, 0, 27);
    window(1);
    set_n(4'd8);
    window(3);
    probe(1'b0, 27);
    expect_ev(0, 0, 0, 1, 27);
    window(1);
    probe(1'b1, 27);

    // nq == N/2 is LEAD: lose lock, then climb to 63 and saturate.
    set_n(4'd4);
    expect_ev(1, 0, 0, 1, 28);
    expect_ev(1, 0, 0, 0, 29);
    for (int c = 30; c <= 63; c++) expect_ev(1, 0, 0, 0, c);
    expect_ev(1, 0, 0, 0, 63);
    expect_ev(1, 0, 0, 0, 63);
    window(112);
    probe(1'b0, 63);

    // Drop en mid-settle, then re-acquire.
    expect_ev(1, 0, 0, 0, 63);
    window(1);
    tick(2);
    expect_ev(0, 0, 0, 0, 32);
    @(negedge clk_ext) en = 1'b0;
    probe(1'b0, 32);
    @(negedge clk_ext) en = 1'b1;
    set_n(4'd8);
    expect_ev(0, 0, 0, 1, 32);
    window(4);
    probe(1'b1, 32);

    // Asynchronous reset mid-settle after a tracking step, then re-acquire.
    set_n(4'd5);
    expect_ev(0, 1, 0, 1, 31);
    window(1);
    tick(2);
    expect_ev(0, 0, 0, 0, 32);
    @(negedge clk_ext) rst = 1'b1;
    tick(2);
    rst = 1'b0;
    probe(1'b0, 32);
    set_n(4'd8);
    expect_ev(0, 0, 0, 1, 32);
    window(4);
    probe(1'b1, 32);

    tick(4);
    fin_req = 1'b1;
    tick(20);
    $display("FAIL timeout monitor did not finish");
    $fatal(1);
  end

endmodule
